// File: rtl/syscall_unit.sv
// syscall_unit: syscall handler FSM for print (v0=1) and exit (v0=10) services
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   SyscallSrc    in   syscall decoded in the decode stage
//   v0, a0, pc    in   service code, service argument, syscall address
//   resume        in   pulse that releases a halt
//   disp_ready    in   display sink accepts disp_data
//   stall         out  freeze PC and decode (combinational)
//   halt          out  CPU halted
//   disp_valid    out  disp_data valid
//   disp_data     out  value to display
//   halt_pc       out  pc of the halting syscall
//   syscall_count out  number of accepted syscalls
module syscall_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        SyscallSrc,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   input  logic [31:0] pc,
   input  logic        resume,
   input  logic        disp_ready,
   output logic        stall,
   output logic        halt,
   output logic        disp_valid,
   output logic [31:0] disp_data,
   output logic [31:0] halt_pc,
   output logic [15:0] syscall_count
);
   typedef enum logic [1:0] {IDLE, PRINT, HALTED, RELEASE} state_t;
   state_t      state_q, state_d;
   logic        halt_q, halt_d, valid_q, valid_d, accept, is_print, is_exit;
   logic [31:0] data_q, data_d, hpc_q, hpc_d;
   logic [15:0] cnt_q, cnt_d;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         halt_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         hpc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         hpc_q   <= hpc_d;
         cnt_q   <= cnt_d;
      end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = is_print ? PRINT : is_exit ? HALTED : IDLE;
         PRINT:   state_d = disp_ready ? RELEASE : PRINT;
         HALTED:  state_d = resume ? RELEASE : HALTED;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      accept   = (state_q == IDLE) && SyscallSrc;
      is_print = accept && (v0 == 32'd1);
      is_exit  = accept && (v0 == 32'd10);
      stall    = is_print || is_exit || (state_q == PRINT) || (state_q == HALTED);
      halt_d   = state_d == HALTED;
      valid_d  = state_d == PRINT;
      data_d   = is_print ? a0 : data_q;
      hpc_d    = is_exit ? pc : hpc_q;
      cnt_d    = cnt_q + {15'd0, accept};
   end
   assign halt          = halt_q;
   assign disp_valid    = valid_q;
   assign disp_data     = data_q;
   assign halt_pc       = hpc_q;
   assign syscall_count = cnt_q;
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: directed self-checking bench for syscall_unit
module tb_syscall_unit;
   logic        clk, rst, SyscallSrc, resume, disp_ready;
   logic [31:0] v0, a0, pc;
   logic        stall, halt, disp_valid;
   logic [31:0] disp_data, halt_pc;
   logic [15:0] syscall_count;
   int          vecs, errs;
   logic [15:0] exp_cnt;

   syscall_unit dut (
      .clk(clk), .rst(rst), .SyscallSrc(SyscallSrc), .v0(v0), .a0(a0), .pc(pc),
      .resume(resume), .disp_ready(disp_ready), .stall(stall), .halt(halt),
      .disp_valid(disp_valid), .disp_data(disp_data), .halt_pc(halt_pc),
      .syscall_count(syscall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; SyscallSrc = 1'b0; v0 = '0; a0 = '0; pc = '0; resume = 1'b0; disp_ready = 1'b0;
      exp_cnt = '0;
      #2;
      vecs++;
      if ({stall, halt, disp_valid} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {stall, halt, disp_valid}); end
      vecs++;
      if ({disp_data, halt_pc, syscall_count} !== 80'd0) begin errs++; $display("FAIL reset_regs got %h/%h/%h want 0/0/0", disp_data, halt_pc, syscall_count); end
      tick;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_print;
      SyscallSrc = 1'b1; v0 = 32'd1; a0 = 32'h2A; disp_ready = 1'b1;
      #1;
      vecs++;
      if ({stall, disp_valid} !== 2'b10) begin errs++; $display("FAIL print_c0 stall/valid got %b want 10", {stall, disp_valid}); end
      tick;
      exp_cnt++;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({stall, disp_valid} !== 2'b11) begin errs++; $display("FAIL print_c1 stall/valid got %b want 11", {stall, disp_valid}); end
      vecs++;
      if (disp_data !== 32'h2A) begin errs++; $display("FAIL print_c1 data got %h want 0000002a", disp_data); end
      vecs++;
      if (syscall_count !== exp_cnt) begin errs++; $display("FAIL print_count got %h want %h", syscall_count, exp_cnt); end
      tick;
      SyscallSrc = 1'b1; v0 = 32'd1; a0 = 32'h55;
      #1;
      vecs++;
      if ({stall, disp_valid} !== 2'b00) begin errs++; $display("FAIL print_release got %b want 00", {stall, disp_valid}); end
      tick;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({stall, disp_valid, syscall_count} !== {2'b00, exp_cnt}) begin errs++; $display("FAIL release_ignores_src got %b/%h want 00/%h", {stall, disp_valid}, syscall_count, exp_cnt); end
      vecs++;
      if (disp_data !== 32'h2A) begin errs++; $display("FAIL release_data got %h want 0000002a", disp_data); end
      tick;
   endtask

   task automatic test_print_wait;
      SyscallSrc = 1'b1; v0 = 32'd1; a0 = 32'hDEADBEEF; disp_ready = 1'b0;
      tick;
      exp_cnt++;
      SyscallSrc = 1'b0; a0 = 32'h0;
      for (int i = 0; i < 6; i++) begin
         disp_ready = (i == 5);
         #1;
         vecs++;
         if ({stall, disp_valid, disp_data} !== {2'b11, 32'hDEADBEEF}) begin errs++; $display("FAIL print_hold%0d got %b/%h want 11/deadbeef", i, {stall, disp_valid}, disp_data); end
         tick;
      end
      disp_ready = 1'b0;
      #1;
      vecs++;
      if ({stall, disp_valid, syscall_count} !== {2'b00, exp_cnt}) begin errs++; $display("FAIL print_wait_end got %b/%h want 00/%h", {stall, disp_valid}, syscall_count, exp_cnt); end
      tick;
   endtask

   task automatic test_halt;
      SyscallSrc = 1'b1; v0 = 32'd10; pc = 32'h00400020; resume = 1'b0;
      #1;
      vecs++;
      if ({stall, halt} !== 2'b10) begin errs++; $display("FAIL halt_accept got %b want 10", {stall, halt}); end
      tick;
      exp_cnt++;
      v0 = 32'd1; pc = 32'h0;
      for (int i = 0; i < 10; i++) begin
         #1;
         vecs++;
         if ({stall, halt, disp_valid, halt_pc} !== {3'b110, 32'h00400020}) begin errs++; $display("FAIL halt_hold%0d got %b/%h want 110/00400020", i, {stall, halt, disp_valid}, halt_pc); end
         tick;
      end
      vecs++;
      if (syscall_count !== exp_cnt) begin errs++; $display("FAIL halt_count got %h want %h", syscall_count, exp_cnt); end
      SyscallSrc = 1'b0; resume = 1'b1;
      tick;
      resume = 1'b0; SyscallSrc = 1'b1; v0 = 32'd5;
      #1;
      vecs++;
      if ({stall, halt, halt_pc} !== {2'b00, 32'h00400020}) begin errs++; $display("FAIL halt_release got %b/%h want 00/00400020", {stall, halt}, halt_pc); end
      tick;
      #1;
      vecs++;
      if (syscall_count !== exp_cnt) begin errs++; $display("FAIL release_no_accept got %h want %h", syscall_count, exp_cnt); end
      tick;
      exp_cnt++;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({stall, halt, syscall_count} !== {2'b00, exp_cnt}) begin errs++; $display("FAIL halt_idle got %b/%h want 00/%h", {stall, halt}, syscall_count, exp_cnt); end
      tick;
   endtask

   task automatic test_other;
      SyscallSrc = 1'b1; v0 = 32'd5; a0 = 32'h1234; pc = 32'h9999; resume = 1'b1; disp_ready = 1'b1;
      #1;
      vecs++;
      if (stall !== 1'b0) begin errs++; $display("FAIL other_stall got %b want 0", stall); end
      tick;
      exp_cnt++;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({halt, disp_valid, syscall_count} !== {2'b00, exp_cnt}) begin errs++; $display("FAIL other_outputs got %b/%h want 00/%h", {halt, disp_valid}, syscall_count, exp_cnt); end
      vecs++;
      if ({disp_data, halt_pc} !== {32'hDEADBEEF, 32'h00400020}) begin errs++; $display("FAIL other_regs got %h/%h want deadbeef/00400020", disp_data, halt_pc); end
      tick;
      resume = 1'b0; disp_ready = 1'b0;
   endtask

   task automatic test_wrap;
      SyscallSrc = 1'b1; v0 = 32'd7;
      while (exp_cnt != 16'hFFFF) begin
         tick;
         exp_cnt++;
      end
      #1;
      vecs++;
      if (syscall_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_pre got %h want ffff", syscall_count); end
      tick;
      SyscallSrc = 1'b0;
      exp_cnt++;
      #1;
      vecs++;
      if (syscall_count !== 16'h0000) begin errs++; $display("FAIL wrap got %h want 0000", syscall_count); end
      tick;
   endtask

   task automatic test_async_reset;
      SyscallSrc = 1'b1; v0 = 32'd1; a0 = 32'hCAFE; disp_ready = 1'b0;
      tick;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if (disp_valid !== 1'b1) begin errs++; $display("FAIL mid_print_valid got %b want 1", disp_valid); end
      #1 rst = 1'b1;
      #1;
      vecs++;
      if ({stall, halt, disp_valid, disp_data, halt_pc, syscall_count} !== 83'd0) begin errs++; $display("FAIL rst_print got %b/%h/%h/%h want all 0", {stall, halt, disp_valid}, disp_data, halt_pc, syscall_count); end
      #1 rst = 1'b0;
      tick;
      SyscallSrc = 1'b1; v0 = 32'd10; pc = 32'h00400100;
      tick;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({halt, halt_pc, syscall_count} !== {1'b1, 32'h00400100, 16'd1}) begin errs++; $display("FAIL mid_halt got %b/%h/%h want 1/00400100/0001", halt, halt_pc, syscall_count); end
      #1 rst = 1'b1;
      #1;
      vecs++;
      if ({stall, halt, disp_valid, disp_data, halt_pc, syscall_count} !== 83'd0) begin errs++; $display("FAIL rst_halt got %b/%h/%h/%h want all 0", {stall, halt, disp_valid}, disp_data, halt_pc, syscall_count); end
      #1 rst = 1'b0;
      tick;
      SyscallSrc = 1'b1; v0 = 32'd1; a0 = 32'h77; disp_ready = 1'b1;
      #1;
      vecs++;
      if (stall !== 1'b1) begin errs++; $display("FAIL post_rst_stall got %b want 1", stall); end
      tick;
      SyscallSrc = 1'b0;
      #1;
      vecs++;
      if ({disp_valid, disp_data, syscall_count} !== {1'b1, 32'h77, 16'd1}) begin errs++; $display("FAIL post_rst_print got %b/%h/%h want 1/00000077/0001", disp_valid, disp_data, syscall_count); end
      tick;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset;
      test_print;
      test_print_wait;
      test_halt;
      test_other;
      test_wrap;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
